// File: rtl/bcd_updown_display_pkg.sv
// Package bcd_disp_pkg: shared constants and types for the BCD up/down
// counter display.
//   SEG_0..SEG_9 : active-low 7-segment patterns {g,f,e,d,c,b,a}
//   SEG_DASH     : pattern shown for any non-BCD digit value
//   SEG_BLANK    : all segments off
//   AN_OFF       : all eight digit anodes off
//   bcd_t        : one 4-bit BCD digit
package bcd_disp_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [7:0] AN_OFF    = 8'hFF;

endpackage

// File: rtl/bcd_updown_display_if.sv
// Interface bcd_updown_display_if: control inputs and display/count outputs
// of the BCD up/down counter display.
//   en, up, load, load_val : counter control (driven by master)
//   count, wrap            : registered BCD count and wrap pulse
//   seg, an, dp            : active-low 7-segment drive
// Modports: master = controller/board side, slave = counter block.
interface bcd_updown_display_if #(
  parameter int NUM_DIGITS = 4
) ();
  logic                    en;
  logic                    up;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic [4*NUM_DIGITS-1:0] count;
  logic                    wrap;
  logic [6:0]              seg;
  logic [7:0]              an;
  logic                    dp;

  modport master (
    output en, up, load, load_val,
    input  count, wrap, seg, an, dp
  );

  modport slave (
    input  en, up, load, load_val,
    output count, wrap, seg, an, dp
  );
endinterface

// File: rtl/bcd_updown_display_seg7.sv
// bcd_to_seg7: combinational BCD digit to active-low 7-segment pattern.
//   digit : 4-bit BCD value
//   seg   : {g,f,e,d,c,b,a}, active-low; values 10..15 show a dash
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  bcd_t       digit,
  output logic [6:0] seg
);
  always_comb begin
    unique case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/bcd_updown_display.sv
// bcd_updown_display: N-digit BCD up/down counter with a time-multiplexed
// common-anode 7-segment driver.
//   clk, rst : clock, synchronous active-high reset
//   bus      : bcd_updown_display_if.slave (en/up/load/load_val in;
//              count/wrap/seg/an/dp out)
// Parameters: NUM_DIGITS (1..8), TICK_DIV (clk cycles per count, >=2),
//             SCAN_DIV (clk cycles per lit digit, >=2).
// Build option: LEADING_ZERO_BLANK_EN blanks digits above the most
// significant nonzero digit (digit 0 always shown).
module bcd_updown_display
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 100_000_000,
  parameter int SCAN_DIV   = 100_000
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_updown_display_if.slave   bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);

  // ---------------- counter ----------------
  logic [PW-1:0]                presc;
  logic                         tick;
  logic [NUM_DIGITS-1:0][3:0]   cnt, cnt_nxt, ld, ld_bcd;
  logic                         carry;
  logic                         wrap_r;

  assign tick = bus.en && (presc == PW'(TICK_DIV - 1));
  assign ld   = bus.load_val;

  // Non-BCD load digits are forced to 0 so cnt only ever holds 0..9.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++)
      ld_bcd[i] = (ld[i] > 4'd9) ? 4'd0 : ld[i];
  end

  // Ripple carry/borrow: carry survives the loop only when every digit
  // rolled over, which is exactly the wrap condition.
  always_comb begin
    cnt_nxt = cnt;
    carry   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (bus.up) begin
          if (cnt[i] >= 4'd9) cnt_nxt[i] = 4'd0;
          else begin
            cnt_nxt[i] = cnt[i] + 4'd1;
            carry      = 1'b0;
          end
        end else begin
          if (cnt[i] == 4'd0) cnt_nxt[i] = 4'd9;
          else begin
            cnt_nxt[i] = cnt[i] - 4'd1;
            carry      = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      presc  <= '0;
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= 1'b0;
      if (bus.load) begin
        // load wins over a coincident tick; prescaler restarts
        cnt   <= ld_bcd;
        presc <= '0;
      end else if (bus.en) begin
        if (tick) begin
          presc  <= '0;
          cnt    <= cnt_nxt;
          wrap_r <= carry;
        end else begin
          presc  <= presc + 1'b1;
        end
      end
    end
  end

  // ---------------- scan ----------------
  logic [SW-1:0] scan;
  logic [2:0]    sidx;

  always_ff @(posedge clk) begin
    if (rst) begin
      scan <= '0;
      sidx <= 3'd0;
    end else if (scan == SW'(SCAN_DIV - 1)) begin
      scan <= '0;
      sidx <= (sidx == 3'(NUM_DIGITS - 1)) ? 3'd0 : sidx + 3'd1;
    end else begin
      scan <= scan + 1'b1;
    end
  end

  // Digit select as an explicit mux so sidx never indexes past NUM_DIGITS.
  bcd_t       dsel;
  logic [6:0] seg_c;
  logic       blank;

  always_comb begin
    dsel = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (sidx == 3'(i)) dsel = cnt[i];
  end

  bcd_to_seg7 u_seg7 (
    .digit (dsel),
    .seg   (seg_c)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the top digit down; a scanned digit i>0 is blank when it and
  // all digits above it are zero.
  logic zero_above;
  always_comb begin
    blank      = 1'b0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (cnt[i] == 4'd0);
      if (sidx == 3'(i)) blank = zero_above;
    end
  end
`else
  assign blank = 1'b0;
`endif

  logic [6:0] seg_r;
  logic [7:0] an_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r <= SEG_BLANK;
      an_r  <= AN_OFF;
    end else if (blank) begin
      seg_r <= SEG_BLANK;
      an_r  <= AN_OFF;
    end else begin
      seg_r <= seg_c;
      an_r  <= ~(8'd1 << sidx);
    end
  end

  assign bus.count = cnt;
  assign bus.wrap  = wrap_r;
  assign bus.seg   = seg_r;
  assign bus.an    = an_r;
  assign bus.dp    = 1'b1;

endmodule

// File: tb/tb_bcd_updown_display.sv
// Directed scoreboard bench for bcd_updown_display (4 digits, TICK_DIV=4,
// SCAN_DIV=3). Expected values come from decimal arithmetic and a local
// segment table; the optional LEADING_ZERO_BLANK_EN build is followed.
module tb_bcd_updown_display;
  localparam int ND = 4, TD = 4, SD = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_updown_display_if #(.NUM_DIGITS(ND)) bus ();

  bcd_updown_display #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   val   = 0;   // expected count as a decimal number

  function automatic logic [6:0] seg_ref(int d);
    logic [6:0] t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return t[d];
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r = '0;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(logic [15:0] b);
    int r = 0;
    for (int i = ND - 1; i >= 0; i--) r = r * 10 + int'(b[4*i +: 4]);
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(string tag, logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_underflow: got %0h want <queued entry>", obs);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  // Called at a negedge where the prescaler holds 0; each tick lands
  // 4 negedges later.
  task automatic step(int n, bit dir);
    int nv;
    bit w;
    for (int k = 0; k < n; k++) begin
      nv = dir ? (val + 1) % 10000 : (val + 9999) % 10000;
      w  = dir ? (val == 9999) : (val == 0);
      push("tick_count", 32'(to_bcd(nv)));
      push("tick_wrap", 32'(w));
      repeat (3) @(negedge clk);
      chk("hold_count", 32'(bus.count), 32'(to_bcd(val)));
      chk("hold_wrap", 32'(bus.wrap), 32'd0);
      @(negedge clk);
      pop_chk(32'(bus.count));
      pop_chk(32'(bus.wrap));
      val = nv;
    end
  endtask

  task automatic do_load(logic [15:0] v, logic [15:0] exp);
    bus.load     = 1'b1;
    bus.load_val = v;
    @(negedge clk);
    bus.load = 1'b0;
    chk("load_count", 32'(bus.count), 32'(exp));
    chk("load_wrap", 32'(bus.wrap), 32'd0);
    val = from_bcd(exp);
  endtask

  // Expected an/seg per digit slot already queued (3 entries per digit
  // pair an,seg repeated); sync on entry into digit 0, then compare.
  task automatic scan_check();
    logic [7:0] prev;
    bit         found = 1'b0;
    prev = bus.an;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.an == 8'hFE && prev != 8'hFE) found = 1'b1;
      else prev = bus.an;
    end
    if (!found) begin
      total++;
      bad++;
      $error("FAIL scan_sync: got an=%0h want FE entry within 40 cycles", bus.an);
      sb.delete();
    end else begin
      for (int s = 0; s < 3 * ND; s++) begin
        if (s != 0) @(negedge clk);
        pop_chk(32'(bus.an));
        pop_chk(32'(bus.seg));
      end
    end
  endtask

  task automatic push_scan(logic [15:0] c);
    logic [7:0] a;
    logic [6:0] sg;
    bit         zero_above;
    for (int d = 0; d < ND; d++) begin
      zero_above = 1'b1;
      for (int j = d; j < ND; j++) if (c[4*j +: 4] != 4'd0) zero_above = 1'b0;
      a  = ~(8'd1 << d);
      sg = seg_ref(int'(c[4*d +: 4]));
`ifdef LEADING_ZERO_BLANK_EN
      if (d != 0 && zero_above) begin
        a  = 8'hFF;
        sg = 7'h7F;
      end
`endif
      for (int k = 0; k < SD; k++) begin
        push("scan_an", 32'(a));
        push("scan_seg", 32'(sg));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.up = 1'b1;
    bus.load = 1'b0;
    bus.load_val = '0;
    repeat (3) @(negedge clk);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_wrap", 32'(bus.wrap), 32'd0);
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    chk("rst_an", 32'(bus.an), 32'hFF);
    chk("rst_dp", 32'(bus.dp), 32'd1);

    // count up 0000..0100
    rst = 1'b0;
    bus.en = 1'b1;
    val = 0;
    step(100, 1'b1);

    // wrap going up
    do_load(16'h9997, 16'h9997);
    step(4, 1'b1);

    // down: borrow chain and wrap
    bus.up = 1'b0;
    do_load(16'h0002, 16'h0002);
    step(4, 1'b0);
    do_load(16'h0010, 16'h0010);
    step(1, 1'b0);
    do_load(16'h1000, 16'h1000);
    step(1, 1'b0);

    // invalid digits load as 0
    bus.up = 1'b1;
    do_load(16'h00A7, 16'h0007);
    step(1, 1'b1);
    do_load(16'hFBC3, 16'h0003);
    step(1, 1'b1);

    // load coinciding with a tick
    repeat (3) @(negedge clk);
    do_load(16'h0042, 16'h0042);
    step(1, 1'b1);

    // freeze with en=0 mid-prescale, then resume
    repeat (2) @(negedge clk);
    bus.en = 1'b0;
    repeat (20) @(negedge clk);
    chk("frozen_count", 32'(bus.count), 32'h0043);
    bus.en = 1'b1;
    @(negedge clk);
    chk("resume_hold", 32'(bus.count), 32'h0043);
    @(negedge clk);
    chk("resume_tick", 32'(bus.count), 32'h0044);

    // display scan
    bus.en = 1'b0;
    do_load(16'h1234, 16'h1234);
    push_scan(16'h1234);
    scan_check();
    do_load(16'h0005, 16'h0005);
    push_scan(16'h0005);
    scan_check();
    do_load(16'h0000, 16'h0000);
    push_scan(16'h0000);
    scan_check();
    chk("dp_off", 32'(bus.dp), 32'd1);

    // reset mid-count
    bus.en = 1'b1;
    do_load(16'h0567, 16'h0567);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_count", 32'(bus.count), 32'd0);
    chk("midrst_an", 32'(bus.an), 32'hFF);
    chk("midrst_seg", 32'(bus.seg), 32'h7F);
    rst = 1'b0;
    val = 0;
    step(1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
